// File: rtl/cpu_control_sequencer.sv
// cpu_control_sequencer
// Microcode sequencer for the 8-bit CPU. A 3-bit step counter walks each
// instruction through T0..T(NUM_STEPS-1). The control word is decoded
// combinationally from the current step, the opcode, the ALU flags and the
// halted bit, so each microstep lasts exactly one clock.
//
// Optional feature: define STEP_SKIP_EN to return to T0 right after the last
// non-empty step of each instruction instead of always running NUM_STEPS steps.
//
// Ports:
//   CLK    - system clock, rising edge
//   CLR_n  - asynchronous active-low reset; also forces all outputs inactive
//   OPCODE - instruction register upper nibble
//   CF, ZF - registered carry / zero flags from the ALU flag register
//   CTRL   - active-high control word:
//            0 CE, 1 CO, 2 J, 3 MI, 4 RI, 5 RO, 6 II, 7 IO,
//            8 AI, 9 AO, 10 BI, 11 SU, 12 OI, 13 HLT
//   EO_n   - active-low ALU output enable
//   FI_n   - active-low flag register load
//   STEP   - current microstep, for debug LEDs
module cpu_control_sequencer #(
  parameter int NUM_STEPS = 5,
  parameter int OPCODE_W  = 4
) (
  input  logic                CLK,
  input  logic                CLR_n,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                CF,
  input  logic                ZF,
  output logic [13:0]         CTRL,
  output logic                EO_n,
  output logic                FI_n,
  output logic [2:0]          STEP
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} step_e;

  localparam int CE  = 0;
  localparam int CO  = 1;
  localparam int J   = 2;
  localparam int MI  = 3;
  localparam int RI  = 4;
  localparam int RO  = 5;
  localparam int II  = 6;
  localparam int IO  = 7;
  localparam int AI  = 8;
  localparam int AO  = 9;
  localparam int BI  = 10;
  localparam int SU  = 11;
  localparam int OI  = 12;
  localparam int HLT = 13;

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0001);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0010);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0011);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'b0100);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'b0101);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'b0110);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'b0111);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'b1000);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);

  localparam step_e LAST_STEP = step_e'(3'(NUM_STEPS - 1));

  step_e       step_q, step_d;
  logic        halted_q, halted_d;
  step_e       end_step;
  logic [13:0] ctrl_raw;
  logic        eo_n_raw;
  logic        fi_n_raw;

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

`ifdef STEP_SKIP_EN
  // Last non-empty step of each instruction; unknown codes behave as NOP.
  // HLT never reaches its end step because it freezes at T2.
  always_comb begin
    end_step = T1;
    case (OPCODE)
      OP_LDA, OP_STA:                         end_step = T3;
      OP_ADD, OP_SUB:                         end_step = T4;
      OP_LDI, OP_JMP, OP_OUT, OP_JC, OP_JZ,
      OP_HLT:                                 end_step = T2;
      default:                                end_step = T1;
    endcase
  end
`else
  assign end_step = LAST_STEP;
`endif

  // The HLT instruction sets halted at the edge ending its T2, leaving the
  // counter parked at T2 until CLR_n clears it.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (step_q == T2 && OPCODE == OP_HLT) begin
        halted_d = 1'b1;
      end else if (step_q == end_step) begin
        step_d = T0;
      end else begin
        step_d = step_e'(step_q + 3'd1);
      end
    end
  end

  // Control word decode. Flags for JC/JZ are used live during T2 so the
  // decode follows whatever the flag register presents this cycle.
  always_comb begin
    ctrl_raw = '0;
    eo_n_raw = 1'b1;
    fi_n_raw = 1'b1;
    if (halted_q) begin
      ctrl_raw[HLT] = 1'b1;
    end else begin
      case (step_q)
        T0: begin
          ctrl_raw[CO] = 1'b1;
          ctrl_raw[MI] = 1'b1;
        end
        T1: begin
          ctrl_raw[RO] = 1'b1;
          ctrl_raw[II] = 1'b1;
          ctrl_raw[CE] = 1'b1;
        end
        T2: begin
          case (OPCODE)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl_raw[IO] = 1'b1;
              ctrl_raw[MI] = 1'b1;
            end
            OP_LDI: begin
              ctrl_raw[IO] = 1'b1;
              ctrl_raw[AI] = 1'b1;
            end
            OP_JMP: begin
              ctrl_raw[IO] = 1'b1;
              ctrl_raw[J]  = 1'b1;
            end
            OP_JC: begin
              ctrl_raw[IO] = CF;
              ctrl_raw[J]  = CF;
            end
            OP_JZ: begin
              ctrl_raw[IO] = ZF;
              ctrl_raw[J]  = ZF;
            end
            OP_OUT: begin
              ctrl_raw[AO] = 1'b1;
              ctrl_raw[OI] = 1'b1;
            end
            OP_HLT: ctrl_raw[HLT] = 1'b1;
            default: ctrl_raw = '0;
          endcase
        end
        T3: begin
          case (OPCODE)
            OP_LDA: begin
              ctrl_raw[RO] = 1'b1;
              ctrl_raw[AI] = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl_raw[RO] = 1'b1;
              ctrl_raw[BI] = 1'b1;
            end
            OP_STA: begin
              ctrl_raw[AO] = 1'b1;
              ctrl_raw[RI] = 1'b1;
            end
            default: ctrl_raw = '0;
          endcase
        end
        T4: begin
          if (OPCODE == OP_ADD || OPCODE == OP_SUB) begin
            ctrl_raw[AI] = 1'b1;
            ctrl_raw[SU] = (OPCODE == OP_SUB);
            eo_n_raw     = 1'b0;
            fi_n_raw     = 1'b0;
          end
        end
        default: ctrl_raw = '0;
      endcase
    end
  end

  // Reset gates the decode directly so the bus goes quiet without a clock.
  assign CTRL = CLR_n ? ctrl_raw : 14'd0;
  assign EO_n = CLR_n ? eo_n_raw : 1'b1;
  assign FI_n = CLR_n ? fi_n_raw : 1'b1;
  assign STEP = step_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb_cpu_control_sequencer
// Directed bench for cpu_control_sequencer: walks instructions step by step
// and compares every output against hand-computed control words. Honours
// STEP_SKIP_EN so the same bench covers both builds.
module tb_cpu_control_sequencer;

  logic        clk;
  logic        clr_n;
  logic [3:0]  opcode;
  logic        cf;
  logic        zf;
  logic [13:0] ctrl;
  logic        eo_n;
  logic        fi_n;
  logic [2:0]  step;

  int total_checks  = 0;
  int passed_checks = 0;

  cpu_control_sequencer #(.NUM_STEPS(5), .OPCODE_W(4)) dut (
    .CLK   (clk),
    .CLR_n (clr_n),
    .OPCODE(opcode),
    .CF    (cf),
    .ZF    (zf),
    .CTRL  (ctrl),
    .EO_n  (eo_n),
    .FI_n  (fi_n),
    .STEP  (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // At most one bus driver (CO, RO, IO, AO, EO) in any step.
  always @(negedge clk) begin
    assert ((int'(ctrl[1]) + int'(ctrl[5]) + int'(ctrl[7]) + int'(ctrl[9]) + int'(!eo_n)) <= 1)
      else $error("[TB] bus driver conflict ctrl=0x%0h eo_n=%0b", ctrl, eo_n);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed === expected) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic c, input logic z);
    opcode = op;
    cf     = c;
    zf     = z;
  endtask

  task automatic checkNow(input string tag, input logic [2:0] exp_step, input logic [13:0] exp_ctrl,
                          input logic exp_eo_n, input logic exp_fi_n);
    checkOutput({tag, "_step"}, 32'(step), 32'(exp_step));
    checkOutput({tag, "_ctrl"}, 32'(ctrl), 32'(exp_ctrl));
    checkOutput({tag, "_eo_n"}, 32'(eo_n), 32'(exp_eo_n));
    checkOutput({tag, "_fi_n"}, 32'(fi_n), 32'(exp_fi_n));
    checkOutput({tag, "_su_gate"}, 32'(ctrl[11] && eo_n), 32'd0);
  endtask

  // Check the current step, then move to the middle of the next one.
  task automatic expectStep(input string tag, input logic [2:0] exp_step, input logic [13:0] exp_ctrl,
                            input logic exp_eo_n, input logic exp_fi_n);
    checkNow(tag, exp_step, exp_ctrl, exp_eo_n, exp_fi_n);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expectFetch(input string tag);
    expectStep({tag, "_t0"}, 3'd0, 14'h000A, 1'b1, 1'b1);
    expectStep({tag, "_t1"}, 3'd1, 14'h0061, 1'b1, 1'b1);
  endtask

  // Empty steps that only exist when step skipping is off.
  task automatic emptyTail(input string tag, input int from_step);
`ifndef STEP_SKIP_EN
    for (int s = from_step; s <= 4; s++) begin
      expectStep($sformatf("%s_t%0d", tag, s), 3'(s), 14'h0000, 1'b1, 1'b1);
    end
`else
    if (from_step > 4) $display("[TB] unexpected tail start %0d", from_step);
`endif
  endtask

  initial begin
    clr_n = 1'b0;
    applyStimulus(4'b0001, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkNow("reset_hold", 3'd0, 14'h0000, 1'b1, 1'b1);
    clr_n = 1'b1;
    #1;

    // LDA
    expectFetch("lda");
    expectStep("lda_t2", 3'd2, 14'h0088, 1'b1, 1'b1);
    expectStep("lda_t3", 3'd3, 14'h0120, 1'b1, 1'b1);
    emptyTail("lda", 4);

    // ADD then SUB
    applyStimulus(4'b0010, 1'b0, 1'b0);
    expectFetch("add");
    expectStep("add_t2", 3'd2, 14'h0088, 1'b1, 1'b1);
    expectStep("add_t3", 3'd3, 14'h0420, 1'b1, 1'b1);
    expectStep("add_t4", 3'd4, 14'h0100, 1'b0, 1'b0);

    applyStimulus(4'b0011, 1'b0, 1'b0);
    expectFetch("sub");
    expectStep("sub_t2", 3'd2, 14'h0088, 1'b1, 1'b1);
    expectStep("sub_t3", 3'd3, 14'h0420, 1'b1, 1'b1);
    expectStep("sub_t4", 3'd4, 14'h0900, 1'b0, 1'b0);

    // JC taken, JC not taken with a live flag change during T2
    applyStimulus(4'b0111, 1'b1, 1'b0);
    expectFetch("jc1");
    expectStep("jc1_t2", 3'd2, 14'h0084, 1'b1, 1'b1);
    emptyTail("jc1", 3);

    applyStimulus(4'b0111, 1'b0, 1'b1);
    expectFetch("jc0");
    checkNow("jc0_t2", 3'd2, 14'h0000, 1'b1, 1'b1);
    cf = 1'b1;
    #1;
    checkNow("jc_live_t2", 3'd2, 14'h0084, 1'b1, 1'b1);
    cf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    emptyTail("jc0", 3);

    // JZ taken / not taken
    applyStimulus(4'b1000, 1'b0, 1'b1);
    expectFetch("jz1");
    expectStep("jz1_t2", 3'd2, 14'h0084, 1'b1, 1'b1);
    emptyTail("jz1", 3);

    applyStimulus(4'b1000, 1'b1, 1'b0);
    expectFetch("jz0");
    expectStep("jz0_t2", 3'd2, 14'h0000, 1'b1, 1'b1);
    emptyTail("jz0", 3);

    // STA, OUT, JMP
    applyStimulus(4'b0100, 1'b0, 1'b0);
    expectFetch("sta");
    expectStep("sta_t2", 3'd2, 14'h0088, 1'b1, 1'b1);
    expectStep("sta_t3", 3'd3, 14'h0210, 1'b1, 1'b1);
    emptyTail("sta", 4);

    applyStimulus(4'b1110, 1'b0, 1'b0);
    expectFetch("out");
    expectStep("out_t2", 3'd2, 14'h1200, 1'b1, 1'b1);
    emptyTail("out", 3);

    applyStimulus(4'b0110, 1'b0, 1'b0);
    expectFetch("jmp");
    expectStep("jmp_t2", 3'd2, 14'h0084, 1'b1, 1'b1);
    emptyTail("jmp", 3);

    // LDI then NOP: step sequence 0,1,2,0,1,0 with skipping, 5+5 otherwise
    applyStimulus(4'b0101, 1'b0, 1'b0);
    expectFetch("ldi");
    expectStep("ldi_t2", 3'd2, 14'h0180, 1'b1, 1'b1);
    emptyTail("ldi", 3);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    expectFetch("nop");
    emptyTail("nop", 2);
    // Unknown opcode behaves as NOP
    applyStimulus(4'b1010, 1'b0, 1'b0);
    expectFetch("undef");
    emptyTail("undef", 2);

    // Async reset during ADD T3, between edges
    applyStimulus(4'b0010, 1'b0, 1'b0);
    expectFetch("addr");
    expectStep("addr_t2", 3'd2, 14'h0088, 1'b1, 1'b1);
    checkNow("addr_t3", 3'd3, 14'h0420, 1'b1, 1'b1);
    #2 clr_n = 1'b0;
    #1;
    checkNow("async_rst", 3'd0, 14'h0000, 1'b1, 1'b1);
    @(negedge clk);
    clr_n = 1'b1;
    #1;
    expectFetch("post_rst");
    expectStep("post_rst_t2", 3'd2, 14'h0088, 1'b1, 1'b1);
    checkNow("post_rst_t3", 3'd3, 14'h0420, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkNow("post_rst_t4", 3'd4, 14'h0100, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);

    // HLT freezes at T2 until reset, regardless of later opcodes
    applyStimulus(4'b1111, 1'b0, 1'b0);
    expectFetch("hlt");
    expectStep("hlt_t2", 3'd2, 14'h2000, 1'b1, 1'b1);
    applyStimulus(4'b0010, 1'b1, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkNow("halted", 3'd2, 14'h2000, 1'b1, 1'b1);
    #2 clr_n = 1'b0;
    #1;
    checkNow("halt_rst", 3'd0, 14'h0000, 1'b1, 1'b1);
    @(negedge clk);
    clr_n = 1'b1;
    applyStimulus(4'b0001, 1'b0, 1'b0);
    #1;
    expectFetch("resume");
    expectStep("resume_t2", 3'd2, 14'h0088, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
